// File: rtl/divider_if.sv
// Handshake and operand bundle between the EX stage and the divider.
// Master drives operands and pipeline control; slave returns the result.
interface divider_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            pipe_enable;
  logic            flush;
  logic [XLEN-1:0] result;
  logic            done;
  logic            div_wait;

  modport master (
    output start, op, dividend, divisor,
    output pipe_enable, flush,
    input  result, done, div_wait
  );

  modport slave (
    input  start, op, dividend, divisor,
    input  pipe_enable, flush,
    output result, done, div_wait
  );
endinterface

// File: rtl/divider.sv
// RV32M iterative radix-2 restoring divider for the EX stage.
// Stalls the pipe while busy and holds its result until EX advances.
module divider #(
  parameter int XLEN = 32
) (
  input logic      clk,
  input logic      rst_n,
  divider_if.slave bus
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2*XLEN:0] work;
  logic [XLEN-1:0] dvsr;
  logic [XLEN-1:0] res_q;
  logic            done_q;
  logic            neg_q;
  logic            neg_r;
  logic            is_rem;

  logic            sgn;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic            div_zero;
  logic            ovf;
  logic [2*XLEN:0] shl;
  logic [XLEN+1:0] diff;
  logic [2*XLEN:0] nxt;
  logic [XLEN-1:0] q;
  logic [XLEN-1:0] r;
  logic [XLEN-1:0] fix;

  assign sgn   = ~bus.op[0];
  assign a_neg = sgn & bus.dividend[XLEN-1];
  assign b_neg = sgn & bus.divisor[XLEN-1];
  assign abs_a = a_neg ? '0 - bus.dividend : bus.dividend;
  assign abs_b = b_neg ? '0 - bus.divisor : bus.divisor;

  assign div_zero = (bus.divisor == '0);
  assign ovf = sgn
             & (bus.dividend == {1'b1, {(XLEN-1){1'b0}}})
             & (bus.divisor == '1);

  // Negative trial difference means the divisor did not fit: restore.
  assign shl  = work << 1;
  assign diff = {1'b0, shl[2*XLEN:XLEN]} - {2'b00, dvsr};
  assign nxt  = diff[XLEN+1] ? shl
              : {diff[XLEN:0], shl[XLEN-1:1], 1'b1};

  assign q   = nxt[XLEN-1:0];
  assign r   = nxt[2*XLEN-1:XLEN];
  assign fix = is_rem ? (neg_r ? '0 - r : r)
                      : (neg_q ? '0 - q : q);

  assign bus.div_wait = ~bus.flush
                      & ((state == IDLE & bus.start)
                      | (state == BUSY));
  assign bus.done     = done_q & ~bus.flush;
  assign bus.result   = bus.flush ? '0 : res_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      work   <= '0;
      dvsr   <= '0;
      res_q  <= '0;
      done_q <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      is_rem <= 1'b0;
    end else if (bus.flush) begin
      state  <= IDLE;
      cnt    <= '0;
      work   <= '0;
      res_q  <= '0;
      done_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            is_rem <= bus.op[1];
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            cnt    <= '0;
            if (div_zero) begin
              res_q  <= bus.op[1] ? bus.dividend : '1;
              done_q <= 1'b1;
              state  <= DONE;
            end else if (ovf) begin
              res_q  <= bus.op[1] ? '0 : bus.dividend;
              done_q <= 1'b1;
              state  <= DONE;
            end else begin
              work  <= {{(XLEN+1){1'b0}}, abs_a};
              dvsr  <= abs_b;
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          work <= nxt;
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(XLEN-1)) begin
            res_q  <= fix;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          if (bus.pipe_enable) begin
            res_q  <= '0;
            done_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_divider.sv
// Directed-vector bench for the EX-stage divider.
// Inputs change on the falling edge; outputs sampled 1ns later.
module tb_divider;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  divider_if #(.XLEN(32)) bus ();

  divider #(.XLEN(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present an op, hold start, count stall cycles until done (bounded).
  task automatic issue(input logic [1:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       output int waits,
                       output logic [31:0] res,
                       output logic got);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = op;
    bus.dividend = a;
    bus.divisor = b;
    bus.pipe_enable = 1'b0;
    waits = 0;
    res = '0;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (bus.done) begin
        got = 1'b1;
        res = bus.result;
        break;
      end
      if (bus.div_wait) waits++;
      @(negedge clk);
    end
  endtask

  task automatic retire();
    bus.pipe_enable = 1'b1;
    bus.start = 1'b0;
    @(posedge clk);
    #1 bus.pipe_enable = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.op = 2'd0;
    bus.dividend = '0;
    bus.divisor = '0;
    bus.pipe_enable = 1'b0;
    bus.flush = 1'b0;
    #12;
    checks++;
    if (bus.done !== 1'b0) begin
      failures++;
      $display("FAIL reset_done got=%b want=0", bus.done);
    end
    checks++;
    if (bus.result !== 32'd0) begin
      failures++;
      $display("FAIL reset_result got=%h want=0", bus.result);
    end
    checks++;
    if (bus.div_wait !== 1'b0) begin
      failures++;
      $display("FAIL reset_wait got=%b want=0", bus.div_wait);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_unsigned();
    int w;
    logic [31:0] r;
    logic g;
    issue(2'd1, 32'd100, 32'd7, w, r, g);
    checks++;
    if (w !== 33 || g !== 1'b1) begin
      failures++;
      $display("FAIL divu_latency got=%0d done=%b want=33", w, g);
    end
    checks++;
    if (r !== 32'd14) begin
      failures++;
      $display("FAIL divu_result got=%h want=%h", r, 32'd14);
    end
    retire();
    issue(2'd3, 32'd100, 32'd7, w, r, g);
    checks++;
    if (r !== 32'd2 || g !== 1'b1) begin
      failures++;
      $display("FAIL remu_result got=%h want=%h", r, 32'd2);
    end
    retire();
  endtask

  task automatic test_signed();
    logic [1:0]  ops [3] = '{2'd0, 2'd2, 2'd2};
    logic [31:0] as  [3] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7};
    logic [31:0] bs  [3] = '{32'd2, 32'd2, 32'hFFFF_FFFE};
    logic [31:0] exp [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1};
    int w;
    logic [31:0] r;
    logic g;
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], as[i], bs[i], w, r, g);
      checks++;
      if (r !== exp[i] || w !== 33 || g !== 1'b1) begin
        failures++;
        $display("FAIL signed_%0d got=%h waits=%0d want=%h waits=33",
                 i, r, w, exp[i]);
      end
      retire();
    end
  endtask

  task automatic test_fast_path();
    logic [1:0]  ops [4] = '{2'd0, 2'd3, 2'd0, 2'd2};
    logic [31:0] as  [4] = '{32'd5, 32'h1234, 32'h8000_0000,
                             32'h8000_0000};
    logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF,
                             32'hFFFF_FFFF};
    logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'h1234, 32'h8000_0000,
                             32'd0};
    int w;
    logic [31:0] r;
    logic g;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], bs[i], w, r, g);
      checks++;
      if (r !== exp[i] || w !== 1 || g !== 1'b1) begin
        failures++;
        $display("FAIL fast_%0d got=%h waits=%0d want=%h waits=1",
                 i, r, w, exp[i]);
      end
      retire();
    end
  endtask

  task automatic test_flush();
    int w;
    logic [31:0] r;
    logic g;
    logic seen;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = 2'd1;
    bus.dividend = 32'd100;
    bus.divisor = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    #1;
    checks++;
    if (bus.div_wait !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL flush_cycle wait=%b done=%b want=0 0",
               bus.div_wait, bus.done);
    end
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    checks++;
    if (bus.div_wait !== 1'b0) begin
      failures++;
      $display("FAIL flush_idle wait=%b want=0", bus.div_wait);
    end
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      #1 if (bus.done) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL flush_no_done got=%b want=0", seen);
    end
    issue(2'd1, 32'd9, 32'd3, w, r, g);
    checks++;
    if (r !== 32'd3 || w !== 33 || g !== 1'b1) begin
      failures++;
      $display("FAIL flush_next got=%h waits=%0d want=3 waits=33", r, w);
    end
    retire();
  endtask

  task automatic test_stall();
    int w;
    logic [31:0] r;
    logic g;
    logic bad;
    issue(2'd1, 32'd100, 32'd7, w, r, g);
    bad = !g;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      if (bus.done !== 1'b1 || bus.result !== 32'd14
          || bus.div_wait !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      failures++;
      $display("FAIL stall_hold done=%b result=%h want=1 %h",
               bus.done, bus.result, 32'd14);
    end
    retire();
    @(negedge clk);
    #1;
    checks++;
    if (bus.done !== 1'b0 || bus.result !== 32'd0) begin
      failures++;
      $display("FAIL stall_release done=%b result=%h want=0 0",
               bus.done, bus.result);
    end
  endtask

  task automatic test_reset_mid();
    int w;
    logic [31:0] r;
    logic g;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = 2'd1;
    bus.dividend = 32'd100;
    bus.divisor = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.done !== 1'b0 || bus.result !== 32'd0
        || bus.div_wait !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid done=%b result=%h wait=%b want=0 0 0",
               bus.done, bus.result, bus.div_wait);
    end
    @(negedge clk);
    rst_n = 1'b1;
    issue(2'd1, 32'd100, 32'd7, w, r, g);
    checks++;
    if (r !== 32'd14 || w !== 33 || g !== 1'b1) begin
      failures++;
      $display("FAIL reset_next got=%h waits=%0d want=e waits=33", r, w);
    end
    retire();
  endtask

  task automatic test_back_to_back();
    int w;
    logic [31:0] r;
    logic g;
    issue(2'd1, 32'd1000, 32'd10, w, r, g);
    retire();
    issue(2'd3, 32'd1003, 32'd10, w, r, g);
    checks++;
    if (r !== 32'd3 || w !== 33 || g !== 1'b1) begin
      failures++;
      $display("FAIL b2b_second got=%h waits=%0d want=3 waits=33", r, w);
    end
    retire();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_fast_path();
    test_flush();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
